// File: rtl/dtw_subseq_core.sv
// Subsequence DTW engine: loads an N-sample query from the source FIFO, then streams
// reference samples one column per cycle and tracks the minimum last-row cost.
module dtw_subseq_core #(
  parameter int WORD_LEN   = 16,
  parameter int AXIS_WIDTH = 32,
  parameter int SQG_LEN    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rs,
  output logic                  running,
  output logic                  src_fifo_clear,
  output logic                  src_fifo_rden,
  input  logic                  src_fifo_empty,
  input  logic [AXIS_WIDTH-1:0] src_fifo_data,
  input  logic [31:0]           reference_len,
  output logic [WORD_LEN-1:0]   best_score,
  output logic [31:0]           best_position,
  output logic                  done
);

  localparam int RW = (SQG_LEN > 1) ? $clog2(SQG_LEN) : 1;
  localparam logic [WORD_LEN-1:0] SAT = '1;

  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, FINISH, DONE} state_t;

  state_t              state;
  logic [RW-1:0]       row;
  logic [31:0]         col_idx;
  logic [31:0]         len;
  logic [31:0]         cmp_pos;
  logic                cmp_pending;
  logic [WORD_LEN-1:0] q        [SQG_LEN];
  logic [WORD_LEN-1:0] col      [SQG_LEN];
  logic [WORD_LEN-1:0] col_next [SQG_LEN];
  logic [WORD_LEN-1:0] sample;
  logic                first_col;
  logic                unused_data;

  assign sample      = src_fifo_data[WORD_LEN-1:0];
  assign unused_data = ^src_fifo_data[AXIS_WIDTH-1:WORD_LEN];
  assign first_col   = (col_idx == 32'd0);

  // A start/abort strobe wins over a pop, and nothing is popped during the flush cycle.
  assign src_fifo_rden = ((state == LOAD) || (state == SEARCH)) && !src_fifo_empty
                         && !src_fifo_clear && !rs;

  // One full column per sample; D[-1][*] = 0 and D[i][-1] saturated.
  always_comb begin : column_calc
    logic [WORD_LEN-1:0] diff, up, left, diag, m, prev_next, prev_col;
    logic [WORD_LEN:0]   sum;
    diff      = '0;
    up        = '0;
    left      = '0;
    diag      = '0;
    m         = '0;
    sum       = '0;
    prev_next = '0;
    prev_col  = '0;
    for (int i = 0; i < SQG_LEN; i++) begin
      diff = (q[i] > sample) ? (q[i] - sample) : (sample - q[i]);
      up   = prev_next;
      left = first_col ? SAT : col[i];
      diag = first_col ? SAT : prev_col;
      m    = (up < left) ? up : left;
      m    = (diag < m) ? diag : m;
      sum  = {1'b0, diff} + {1'b0, m};
      col_next[i] = sum[WORD_LEN] ? SAT : sum[WORD_LEN-1:0];
      prev_next   = col_next[i];
      prev_col    = col[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      running        <= 1'b0;
      done           <= 1'b0;
      src_fifo_clear <= 1'b0;
      best_score     <= SAT;
      best_position  <= '0;
      row            <= '0;
      col_idx        <= '0;
      len            <= '0;
      cmp_pending    <= 1'b0;
      cmp_pos        <= '0;
      for (int i = 0; i < SQG_LEN; i++) begin
        q[i]   <= '0;
        col[i] <= '0;
      end
    end else begin
      src_fifo_clear <= 1'b0;
      cmp_pending    <= 1'b0;
      // Strictly-less keeps the earliest reference index on ties.
      if (cmp_pending && !rs && (col[SQG_LEN-1] < best_score)) begin
        best_score    <= col[SQG_LEN-1];
        best_position <= cmp_pos;
      end
      case (state)
        IDLE: begin
          if (rs) begin
            state          <= LOAD;
            running        <= 1'b1;
            src_fifo_clear <= 1'b1;
            len            <= reference_len;
            best_score     <= SAT;
            best_position  <= '0;
            done           <= 1'b0;
            row            <= '0;
            col_idx        <= '0;
          end
        end
        LOAD: begin
          if (rs) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
          end else if (src_fifo_rden) begin
            q[row] <= sample;
            if (row == RW'(SQG_LEN - 1)) begin
              state <= (len == 32'd0) ? FINISH : SEARCH;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        SEARCH: begin
          if (rs) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
          end else if (src_fifo_rden) begin
            for (int i = 0; i < SQG_LEN; i++) col[i] <= col_next[i];
            cmp_pending <= 1'b1;
            cmp_pos     <= col_idx;
            col_idx     <= col_idx + 32'd1;
            if (col_idx == len - 32'd1) state <= FINISH;
          end
        end
        FINISH: begin
          if (rs) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
          end else begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE: begin
          if (rs) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_subseq_core.sv
// Directed bench for dtw_subseq_core with a small FIFO model and hand-computed results.
module tb_dtw_subseq_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        rs;
  logic        running;
  logic        src_fifo_clear;
  logic        src_fifo_rden;
  logic        src_fifo_empty;
  logic [31:0] src_fifo_data;
  logic [31:0] reference_len;
  logic [15:0] best_score;
  logic [31:0] best_position;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [64];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   cyc = 0;
  int   last_pop = 0;
  int   pops = 0;
  logic stall = 1'b0;
  logic stall_mode = 1'b0;
  logic chk_stall = 1'b0;

  logic [15:0] qv [5];
  logic [15:0] rv [32];

  always #5 clk = ~clk;

  dtw_subseq_core #(.WORD_LEN(16), .AXIS_WIDTH(32), .SQG_LEN(5)) dut (
    .clk(clk), .rst(rst), .rs(rs), .running(running),
    .src_fifo_clear(src_fifo_clear), .src_fifo_rden(src_fifo_rden),
    .src_fifo_empty(src_fifo_empty), .src_fifo_data(src_fifo_data),
    .reference_len(reference_len), .best_score(best_score),
    .best_position(best_position), .done(done)
  );

  assign src_fifo_empty = stall || (rd_ptr == wr_ptr);
  assign src_fifo_data  = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_fifo_clear) begin
      rd_ptr <= wr_ptr;
    end else if (src_fifo_rden) begin
      rd_ptr   <= rd_ptr + 1;
      pops     <= pops + 1;
      last_pop <= cyc;
    end
  end

  always @(negedge clk) stall <= stall_mode ? ~stall : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_stall) check("rden_while_empty", {31'd0, src_fifo_rden && src_fifo_empty}, 32'd0);
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  task automatic load_words(input int len);
    for (int i = 0; i < 5; i++) push({16'd0, qv[i]});
    for (int j = 0; j < len; j++) push({16'd0, rv[j]});
  endtask

  task automatic start_job(input logic [31:0] len);
    reference_len = len;
    rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;
    check("clear_pulse", {31'd0, src_fifo_clear}, 32'd1);
    check("running_start", {31'd0, running}, 32'd1);
    check("rden_in_clear", {31'd0, src_fifo_rden}, 32'd0);
    check("best_reset", {16'd0, best_score}, 32'h0000_FFFF);
    check("pos_reset", best_position, 32'd0);
    check("done_cleared", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("clear_one_cycle", {31'd0, src_fifo_clear}, 32'd0);
  endtask

  task automatic run_job(input int len, input logic [15:0] exp_s, input logic [31:0] exp_p,
                         input string tag);
    int p0;
    int n;
    p0 = pops;
    start_job(len);
    load_words(len);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_score"}, {16'd0, best_score}, {16'd0, exp_s});
    check({tag, "_pos"}, best_position, exp_p);
    check({tag, "_latency"}, cyc - last_pop, 32'd2);
    check({tag, "_pops"}, pops - p0, 5 + len);
    check({tag, "_running"}, {31'd0, running}, 32'd0);
    rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    check({tag, "_retained"}, {16'd0, best_score}, {16'd0, exp_s});
  endtask

  task automatic set_exact();
    for (int i = 0; i < 5; i++) qv[i] = 16'(10 * (i + 1));
    for (int j = 0; j < 32; j++) rv[j] = 16'd0;
    for (int j = 0; j < 5; j++) rv[10 + j] = 16'(10 * (j + 1));
  endtask

  initial begin
    int n;
    int p0;
    rst = 1'b1;
    rs = 1'b0;
    reference_len = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_clear", {31'd0, src_fifo_clear}, 32'd0);
    check("rst_rden", {31'd0, src_fifo_rden}, 32'd0);
    check("rst_best", {16'd0, best_score}, 32'h0000_FFFF);
    check("rst_pos", best_position, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    set_exact();
    run_job(25, 16'd0, 32'd14, "exact");

    for (int i = 0; i < 5; i++) qv[i] = 16'd1;
    for (int j = 0; j < 3; j++) rv[j] = 16'd3;
    run_job(3, 16'd10, 32'd0, "tie");

    set_exact();
    stall_mode = 1'b1;
    chk_stall = 1'b1;
    run_job(25, 16'd0, 32'd14, "stall");
    stall_mode = 1'b0;
    chk_stall = 1'b0;
    @(negedge clk);

    run_job(0, 16'hFFFF, 32'd0, "zero");

    for (int i = 0; i < 5; i++) qv[i] = 16'hFFFF;
    for (int j = 0; j < 3; j++) rv[j] = 16'd0;
    run_job(3, 16'hFFFF, 32'd0, "sat");

    // Abort mid-SEARCH after seven reference columns.
    set_exact();
    p0 = pops;
    start_job(25);
    load_words(25);
    n = 0;
    while (pops < p0 + 12 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", {31'd0, (pops >= p0 + 12)}, 32'd1);
    check("abort_pre_best", {16'd0, best_score}, 32'd150);
    rs = 1'b1;
    #1;
    check("abort_rden_blocked", {31'd0, src_fifo_rden}, 32'd0);
    @(negedge clk);
    rs = 1'b0;
    check("abort_running", {31'd0, running}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_done_later", {31'd0, done}, 32'd0);
    check("abort_idle", {31'd0, running}, 32'd0);
    run_job(25, 16'd0, 32'd14, "restart");

    // Asynchronous reset in the middle of LOAD.
    start_job(25);
    push({16'd0, qv[0]});
    push({16'd0, qv[1]});
    @(negedge clk);
    @(negedge clk);
    check("load_running", {31'd0, running}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_running", {31'd0, running}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_clear", {31'd0, src_fifo_clear}, 32'd0);
    check("arst_rden", {31'd0, src_fifo_rden}, 32'd0);
    check("arst_best", {16'd0, best_score}, 32'h0000_FFFF);
    check("arst_pos", best_position, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {31'd0, running}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dtw_subseq_core.md
# dtw_subseq_core

Subsequence dynamic-time-warping (DTW) engine. It loads a fixed-length query squiggle from a source FIFO and then streams `reference_len` reference samples from the same FIFO, one column per sample. It reports the minimum last-row DTW cost and the reference index where that cost occurs. It sits behind the AXI-Stream-fed source FIFO and is controlled by a register-level run/stop strobe.

## Interface
- `WORD_LEN`, 16: sample and score width in bits.
- `AXIS_WIDTH`, 32: source FIFO data width in bits.
- `SQG_LEN`, 5: query length N, the number of DTW rows.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `rs` in 1: run/stop strobe, one-cycle pulse.
- `running` out 1: high while a job is in progress.
- `src_fifo_clear` out 1: one-cycle FIFO flush request.
- `src_fifo_rden` out 1: FIFO pop (first-word-fall-through).
- `src_fifo_empty` in 1: FIFO empty flag.
- `src_fifo_data` in `AXIS_WIDTH`: FIFO head word; only bits `[WORD_LEN-1:0]` are used, as an unsigned sample.
- `reference_len` in 32: number of reference samples; sampled on start.
- `best_score` out `WORD_LEN`: minimum final-row cost.
- `best_position` out 32: 0-based reference index of `best_score`.
- `done` out 1: result valid; held high until the next start.

## Operation
- **States:** IDLE, LOAD, SEARCH, FINISH, DONE.
- **IDLE:**
  - `rs` moves to LOAD.
  - In the same edge: pulse `src_fifo_clear` for one cycle, latch `reference_len`, set `best_score` to all-ones, set `best_position` to 0, clear `done`, and reset the row/column counters.
- **Consuming a sample:**
  - In LOAD and SEARCH, `src_fifo_rden = !src_fifo_empty`.
  - The head word is consumed in any cycle where `rden` is high.
  - While the FIFO is empty the core stalls with no state change.
- **LOAD:**
  - Consumed words fill `q[0..N-1]` in order.
  - After the N-th word, go to SEARCH; if the latched length is 0, go to FINISH instead.
- **SEARCH recurrence:**
  - Reference sample `r_j` computes a column `D[i][j] = |q_i - r_j| + min(D[i-1][j], D[i][j-1], D[i-1][j-1])`.
  - Boundaries: `D[-1][*] = 0` (free start), and `D[i][-1]` is saturated (all-ones) for every i ≥ 0.
- **Arithmetic:**
  - Unsigned WORD_LEN-bit absolute difference.
  - Additions saturate at `2^WORD_LEN-1`.
  - The column is held in N registers.
- **Best tracking:**
  - After each column, compare `D[N-1][j]` to `best_score`.
  - Update only on strictly less, so the first minimum wins.
  - `best_position` is set to j.
- **SEARCH exit:** after the `reference_len`-th sample is consumed, go to FINISH.
- **FINISH:** one cycle for the final comparison, then DONE.
- **DONE:** `done = 1`, `running = 0`, results stable.
- **`rs` pulse handling:**
  - In DONE: return to IDLE; `done` clears and the results are retained.
  - In LOAD, SEARCH or FINISH: abort to IDLE, with `done` left at 0.
- `running` is high in LOAD, SEARCH and FINISH.

## Timing
- **Reset values:**
  - State: IDLE.
  - Outputs: `running`, `done`, `src_fifo_clear` and `src_fifo_rden` are 0; `best_score` is all-ones; `best_position` is 0.
  - Column registers: cleared.
- **Start:** an `rs` high in cycle t gives `src_fifo_clear` = 1 and `running` = 1 in cycle t+1.
  - `rden` is forced low during the clear cycle.
  - The first pop may occur in cycle t+2.
- **Throughput:** one sample per cycle when the FIFO is non-empty.
  - The column for sample j is registered at the end of its consume cycle.
  - The best-score compare is registered one cycle later.
- **Latency:** last reference sample consumed in cycle k gives `done` = 1 in cycle k+2.
  - The best-score outputs are final no later than that cycle.
- **`rs` priority:** `rs` coincident with a FIFO pop takes priority, so the pop does not occur (`rden` = 0 that cycle).
- **Reset mid-operation:** asynchronous return to the reset values; any partial job is discarded.
- **`reference_len` changes after start:** ignored.

## Test plan
- **Exact match:**
  - Stimulus: N=5, q = 10,20,30,40,50; reference length 25, all zeros except r10..r14 = 10,20,30,40,50.
  - Required: `best_score` = 0, `best_position` = 14, `done` 2 cycles after the last pop.
- **Tie and first-minimum rule:**
  - Stimulus: q = 1,1,1,1,1; reference 3,3,3 (length 3).
  - Required: every `D[4][j]` = 10, so `best_score` = 10 and `best_position` = 0.
- **Empty stall:**
  - Stimulus: repeat the exact-match case with `src_fifo_empty` toggled high every other cycle.
  - Required: `rden` never asserts while empty; results are identical to the exact-match case.
- **Zero length:**
  - Stimulus: `reference_len` = 0, query loaded.
  - Required: `done` with `best_score` = 0xFFFF and `best_position` = 0; no reference pops.
- **Abort and restart:**
  - Stimulus: `rs` pulse mid-SEARCH.
  - Required: `running` drops the next cycle, `done` stays 0.
  - Follow-up: a new `rs` pulse gives `src_fifo_clear` for one cycle and best reset to 0xFFFF.
- **Saturation and async reset:**
  - Stimulus: q all 0xFFFF against reference all 0.
  - Required: `best_score` = 0xFFFF (saturated).
  - Follow-up: asserting `rst` mid-LOAD immediately returns all outputs to their reset values.
